// File: rtl/np_fc_accumulator_pkg.sv
// Shared network parameters, widths and state encoding for the FC accumulator.
// Optional macro NP_FC_ACC_RELU_EN enables ReLU clamping in np_sat_shift.
package np_fc_accumulator_pkg;

   localparam int ADDR_MAX       = 242;
   localparam int NUM_KERNELS    = 4;
   localparam int NUM_TERMS_DEF  = ADDR_MAX * NUM_KERNELS;
   localparam int LANES_DEF      = 4;
   localparam int PROD_W         = 16;
   localparam int ACC_W          = 28;
   localparam int OUT_W          = 8;
   localparam int FRAC_SHIFT_DEF = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_BIAS,
      S_SCALE,
      S_OUT
   } state_t;

   // One spare bit so a saturated counter always reads above any term count.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1) + 1;
   endfunction

endpackage

// File: rtl/np_sat_shift.sv
// Per-lane arithmetic right shift, optional ReLU and saturation to OUT_WIDTH.
// ReLU clamping is compiled in when NP_FC_ACC_RELU_EN is defined.
module np_sat_shift
   import np_fc_accumulator_pkg::*;
#(
   parameter int ACC_WIDTH  = ACC_W,
   parameter int OUT_WIDTH  = OUT_W,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [OUT_WIDTH-1:0] result
);

   localparam logic signed [ACC_WIDTH-1:0] OMAX =
      ACC_WIDTH'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
   localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;

   logic signed [ACC_WIDTH-1:0] shifted;
   logic signed [ACC_WIDTH-1:0] clipped;

   always_comb begin
      shifted = $signed(acc) >>> FRAC_SHIFT;
      clipped = shifted;
`ifdef NP_FC_ACC_RELU_EN
      if (shifted[ACC_WIDTH-1]) clipped = '0;
`endif
      if (clipped > OMAX)
         result = OMAX[OUT_WIDTH-1:0];
      else if (clipped < OMIN)
         result = OMIN[OUT_WIDTH-1:0];
      else
         result = clipped[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/np_fc_accumulator.sv
// FC accumulator: sums a product sweep per lane, adds bias, rescales, saturates.
// Build option NP_FC_ACC_RELU_EN clamps negative results to zero.
module np_fc_accumulator
   import np_fc_accumulator_pkg::*;
#(
   parameter int LANES      = LANES_DEF,
   parameter int PROD_WIDTH = PROD_W,
   parameter int ACC_WIDTH  = ACC_W,
   parameter int OUT_WIDTH  = OUT_W,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
   parameter int NUM_TERMS  = NUM_TERMS_DEF
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        prod_valid,
   input  logic                        prod_last,
   input  logic [LANES*PROD_WIDTH-1:0] product,
   input  logic [LANES*ACC_WIDTH-1:0]  bias,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*OUT_WIDTH-1:0]  result,
   output logic                        busy,
   output logic                        count_err
);

   localparam int CNT_W = cnt_width(NUM_TERMS);
   localparam logic [CNT_W-1:0] TERMS = CNT_W'(NUM_TERMS);

   state_t                 state;
   logic [ACC_WIDTH-1:0]   acc [LANES];
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [LANES*OUT_WIDTH-1:0] scaled;

   function automatic logic [ACC_WIDTH-1:0] sat_add(
      input logic [ACC_WIDTH-1:0] a,
      input logic [ACC_WIDTH-1:0] b
   );
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return s[ACC_WIDTH-1:0];
   endfunction

   function automatic logic [ACC_WIDTH-1:0] sext(
      input logic [PROD_WIDTH-1:0] p
   );
      return {{(ACC_WIDTH-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
   endfunction

   assign cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
   assign busy    = (state != S_IDLE);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      np_sat_shift #(
         .ACC_WIDTH  (ACC_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH),
         .FRAC_SHIFT (FRAC_SHIFT)
      ) u_sat (
         .acc    (acc[i]),
         .result (scaled[i*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         count_err <= 1'b0;
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (start) begin
         // Restart from any state; a beat in this cycle is dropped.
         state     <= S_ACCUM;
         cnt       <= '0;
         out_valid <= 1'b0;
         count_err <= 1'b0;
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
         case (state)
            S_ACCUM: begin
               if (prod_valid) begin
                  for (int i = 0; i < LANES; i++)
                     acc[i] <= sat_add(acc[i],
                        sext(product[i*PROD_WIDTH +: PROD_WIDTH]));
                  cnt <= cnt_nxt;
                  if (prod_last) begin
                     state <= S_BIAS;
                     if (cnt_nxt != TERMS) count_err <= 1'b1;
                  end
               end
            end
            S_BIAS: begin
               for (int i = 0; i < LANES; i++)
                  acc[i] <= sat_add(acc[i], bias[i*ACC_WIDTH +: ACC_WIDTH]);
               state <= S_SCALE;
            end
            S_SCALE: begin
               result    <= scaled;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
